// File: rtl/persiana_multinivel.sv
// persiana_multinivel: multi-level blind controller (reloj, reset_n, auto, cmd_valid, cmd_pos, sensor, stop -> pos, motor_up, motor_dn, busy, done)
module persiana_multinivel #(
    parameter int NUM_POS  = 4,
    parameter int POS_W    = 2,
    parameter int STEP_CYC = 8,
    parameter int SENS_W   = 2
) (
    input  logic              reloj,
    input  logic              reset_n,
    input  logic              auto,
    input  logic              cmd_valid,
    input  logic [POS_W-1:0]  cmd_pos,
    input  logic [SENS_W-1:0] sensor,
    input  logic              stop,
    output logic [POS_W-1:0]  pos,
    output logic              motor_up,
    output logic              motor_dn,
    output logic              busy,
    output logic              done
);
    typedef enum logic [1:0] {IDLE, SUBIR, BAJAR, PARADA} state_t;
    localparam logic [POS_W-1:0] MAXP  = POS_W'(NUM_POS - 1);
    localparam logic [7:0]       TLAST = 8'(STEP_CYC - 1);
    state_t           state;
    logic [POS_W-1:0] target, cmd_c, sens_c, tgt_n, pos_s;
    logic [7:0]       timer;
    always_comb begin
        cmd_c    = cmd_pos > MAXP ? MAXP : cmd_pos;
        sens_c   = 32'(sensor) > 32'(NUM_POS - 1) ? MAXP : POS_W'(sensor);
        tgt_n    = cmd_valid ? cmd_c : (state == IDLE && auto) ? MAXP - sens_c : target;
        pos_s    = state == SUBIR ? pos + 1'b1 : pos - 1'b1;
        motor_up = state == SUBIR;
        motor_dn = state == BAJAR;
        busy     = motor_up | motor_dn;
    end
    always_ff @(posedge reloj or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            pos    <= '0;
            target <= '0;
            timer  <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (stop) begin
                state <= PARADA;
                timer <= '0;
            end else if (state == PARADA) begin
                state <= IDLE;
            end else begin
                target <= tgt_n;
                if (state == IDLE) begin
                    state <= tgt_n > pos ? SUBIR : tgt_n < pos ? BAJAR : IDLE;
                end else if (tgt_n == pos) begin
                    state <= IDLE;
                    timer <= '0;
                    done  <= 1'b1;
                end else if ((state == SUBIR) != (tgt_n > pos)) begin
                    state <= IDLE;
                    timer <= '0;
                end else if (timer == TLAST) begin
                    pos   <= pos_s;
                    timer <= '0;
                    if (pos_s == tgt_n) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end else begin
                    timer <= timer + 8'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_persiana_multinivel.sv
// tb_persiana_multinivel: directed self-checking bench for persiana_multinivel
module tb_persiana_multinivel;
    logic       reloj = 1'b0, reset_n = 1'b0, auto = 1'b0, cmd_valid = 1'b0, stop = 1'b0;
    logic [1:0] cmd_pos = '0, sensor = '0, pos;
    logic       motor_up, motor_dn, busy, done;
    int         tests = 0, fails = 0, n;

    persiana_multinivel #(.NUM_POS(4), .POS_W(2), .STEP_CYC(8), .SENS_W(2)) dut (
        .reloj(reloj), .reset_n(reset_n), .auto(auto), .cmd_valid(cmd_valid), .cmd_pos(cmd_pos),
        .sensor(sensor), .stop(stop), .pos(pos), .motor_up(motor_up), .motor_dn(motor_dn),
        .busy(busy), .done(done)
    );

    always #5 reloj = ~reloj;

    always @(negedge reloj) begin
        tests++;
        assert (!(motor_up && motor_dn) && pos <= 2'd3)
        else begin
            fails++;
            $error("FAIL invariant: up=%0d dn=%0d pos=%0d expected exclusive motors, pos<=3", motor_up, motor_dn, pos);
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int k = 1);
        repeat (k) @(negedge reloj);
    endtask

    task automatic wait_done(output int c);
        c = 0;
        do begin
            tick();
            c++;
        end while (!done && c < 200);
        chk("done_timeout", done, 1);
    endtask

    task automatic cmd(input logic [1:0] p);
        cmd_valid = 1'b1;
        cmd_pos   = p;
        tick();
        cmd_valid = 1'b0;
    endtask

    initial begin
        tick(2);
        chk("rst_pos", pos, 0);
        chk("rst_up", motor_up, 0);
        chk("rst_dn", motor_dn, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        reset_n = 1'b1;
        tick();
        // manual open to 3: 24 cycles of motor_up, steps every 8
        cmd(2'd3);
        for (int i = 1; i <= 24; i++) begin
            chk("s1_up", motor_up, 1);
            chk("s1_nodone", done, 0);
            if (i == 9) chk("s1_pos1", pos, 1);
            if (i == 17) chk("s1_pos2", pos, 2);
            tick();
        end
        chk("s1_up_off", motor_up, 0);
        chk("s1_done", done, 1);
        chk("s1_pos3", pos, 3);
        chk("s1_busy", busy, 0);
        tick();
        chk("s1_done_pulse", done, 0);
        // auto mode: bright sensor closes, dim sensor opens partly
        auto   = 1'b1;
        sensor = 2'd3;
        tick();
        chk("s2_dn", motor_dn, 1);
        chk("s2_up", motor_up, 0);
        wait_done(n);
        chk("s2_dn_cycles", n, 24);
        chk("s2_pos0", pos, 0);
        sensor = 2'd1;
        tick();
        chk("s2_up2", motor_up, 1);
        wait_done(n);
        chk("s2_up_cycles", n, 16);
        chk("s2_pos2", pos, 2);
        auto = 1'b0;
        // reversal with dead cycle
        cmd(2'd0);
        wait_done(n);
        chk("s3_pos0", pos, 0);
        cmd(2'd3);
        tick(13);
        chk("s3_pos1", pos, 1);
        chk("s3_up", motor_up, 1);
        cmd(2'd0);
        chk("s3_dead_up", motor_up, 0);
        chk("s3_dead_dn", motor_dn, 0);
        chk("s3_dead_pos", pos, 1);
        chk("s3_dead_done", done, 0);
        tick();
        chk("s3_dn", motor_dn, 1);
        wait_done(n);
        chk("s3_dn_cycles", n, 8);
        chk("s3_pos_end", pos, 0);
        // retarget to current pos while moving
        cmd(2'd3);
        tick(9);
        chk("s4_pos1", pos, 1);
        cmd(2'd1);
        chk("s4_done", done, 1);
        chk("s4_busy", busy, 0);
        chk("s4_pos", pos, 1);
        tick();
        chk("s4_done_pulse", done, 0);
        // stop mid-step, then resume with a full step
        cmd(2'd3);
        tick(3);
        stop = 1'b1;
        tick();
        chk("s5_stop_up", motor_up, 0);
        chk("s5_stop_busy", busy, 0);
        chk("s5_stop_pos", pos, 1);
        tick(5);
        chk("s5_frozen_pos", pos, 1);
        chk("s5_no_done", done, 0);
        stop = 1'b0;
        tick();
        chk("s5_idle_up", motor_up, 0);
        tick();
        chk("s5_resume_up", motor_up, 1);
        wait_done(n);
        chk("s5_resume_cycles", n, 16);
        chk("s5_pos3", pos, 3);
        // stop beats cmd_valid; async reset mid-move
        cmd(2'd0);
        tick(2);
        stop      = 1'b1;
        cmd_valid = 1'b1;
        cmd_pos   = 2'd3;
        tick();
        chk("s6_park_dn", motor_dn, 0);
        chk("s6_park_busy", busy, 0);
        chk("s6_park_pos", pos, 3);
        stop      = 1'b0;
        cmd_valid = 1'b0;
        tick();
        chk("s6_idle_dn", motor_dn, 0);
        tick();
        chk("s6_target_kept", motor_dn, 1);
        tick(10);
        chk("s6_pos2", pos, 2);
        chk("s6_moving", motor_dn, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("s6_arst_pos", pos, 0);
        chk("s6_arst_dn", motor_dn, 0);
        chk("s6_arst_up", motor_up, 0);
        chk("s6_arst_busy", busy, 0);
        chk("s6_arst_done", done, 0);
        tick();
        reset_n = 1'b1;
        tick();
        chk("s6_post_busy", busy, 0);
        chk("s6_post_pos", pos, 0);
        cmd(2'd1);
        wait_done(n);
        chk("s6_post_cycles", n, 8);
        chk("s6_post_pos1", pos, 1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/persiana_multinivel.md
PERSIANA_MULTINIVEL -- requirements
Module: persiana_multinivel

Interface
REQ-001 The block SHALL have parameter NUM_POS, default 4, giving the number of blind positions (0 = fully closed, NUM_POS-1 = fully open); legal range 2..16.
REQ-002 The block SHALL have parameter POS_W, default 2, giving the position width; POS_W SHALL equal ceil(log2(NUM_POS)).
REQ-003 The block SHALL have parameter STEP_CYC, default 8, giving the motor travel time in clock cycles per position step; legal range 2..255.
REQ-004 The block SHALL have parameter SENS_W, default 2, giving the light-sensor width.
REQ-005 The block SHALL have port reloj, input, 1 bit: the single clock, rising-edge active.
REQ-006 The block SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-007 The block SHALL have port auto, input, 1 bit: 1 = automatic (sensor-driven) mode.
REQ-008 The block SHALL have port cmd_valid, input, 1 bit: manual position request strobe.
REQ-009 The block SHALL have port cmd_pos, input, POS_W bits: requested manual position.
REQ-010 The block SHALL have port sensor, input, SENS_W bits: light level (0 = dark).
REQ-011 The block SHALL have port stop, input, 1 bit: emergency stop, level-sensitive.
REQ-012 The block SHALL have port pos, output, POS_W bits: current registered position.
REQ-013 The block SHALL have ports motor_up and motor_dn, output, 1 bit each: motor drive.
REQ-014 The block SHALL have port busy, output, 1 bit: high while in SUBIR or BAJAR.
REQ-015 The block SHALL have port done, output, 1 bit: one-cycle pulse when a move completes.

Function
REQ-016 The FSM SHALL have the states IDLE, SUBIR, BAJAR and PARADA; the outputs SHALL be Moore (registered or state-decoded only).
REQ-017 When cmd_valid=1 in any state other than PARADA, target SHALL load min(cmd_pos, NUM_POS-1); manual SHALL override auto in the same cycle.
REQ-018 In IDLE with auto=1 and cmd_valid=0, target SHALL load (NUM_POS-1) - min(sensor, NUM_POS-1), so a brighter sensor level gives a more closed blind.
REQ-019 Auto retargeting SHALL occur only in IDLE; the sensor SHALL be ignored while moving.
REQ-020 From IDLE, the next state SHALL be SUBIR if target>pos, BAJAR if target<pos, and IDLE otherwise.
REQ-021 In SUBIR/BAJAR the step timer SHALL count 0..STEP_CYC-1; on the terminal count pos SHALL move by +1/-1 and the timer SHALL clear.
REQ-022 When the updated pos equals target, the FSM SHALL return to IDLE and done SHALL pulse high for exactly 1 cycle.
REQ-023 A retarget in the same direction SHALL continue without a timer reset.
REQ-024 A retarget requiring a direction reversal SHALL force IDLE for 1 cycle with both motors off (dead time) before entering the opposite state; the partial step SHALL be discarded and pos unchanged.
REQ-025 A retarget equal to the current pos while moving SHALL go to IDLE on the next cycle, with done pulsed.
REQ-026 pos SHALL saturate: it never exceeds NUM_POS-1 and never drops below 0.
REQ-027 motor_up SHALL be 1 only in SUBIR, motor_dn SHALL be 1 only in BAJAR, and they SHALL never be 1 simultaneously.
REQ-028 stop=1 SHALL force PARADA on the next edge from any state; in PARADA the motors SHALL be off, the timer cleared and cmd_valid ignored.
REQ-029 On stop=0 the FSM SHALL leave PARADA to IDLE, keeping target, so the interrupted move resumes.
REQ-030 stop SHALL have priority over cmd_valid on the same cycle.
REQ-031 done SHALL NOT pulse on a stop-interrupted move.

Reset
REQ-032 While reset_n=0 the block SHALL hold: state=IDLE, pos=0, target=0, timer=0, motor_up=0, motor_dn=0, busy=0, done=0; reset is asynchronous.
REQ-033 Reset asserted mid-move SHALL abandon the move immediately; after release the FSM SHALL start in IDLE with pos=0.

Verification (NUM_POS=4, STEP_CYC=8)
REQ-034 Scenario: from reset, cmd_valid with cmd_pos=3 -> motor_up=1 for 24 cycles, pos steps 1,2,3 every 8 cycles, done pulses once, then IDLE.
REQ-035 Scenario: auto=1, sensor=3, pos=3 -> BAJAR to pos=0; then sensor=1 -> SUBIR to pos=2.
REQ-036 Scenario: moving up at pos=1, timer=5, cmd_pos=0 -> 1 dead cycle with both motors 0, then BAJAR; pos reaches 0 after 8 cycles, done=1.
REQ-037 Scenario: stop=1 mid-step -> motors off next cycle, pos frozen; stop=0 -> move resumes with a full 8-cycle step and done at the original target.
REQ-038 Scenario: cmd_pos=3 and stop=1 in the same cycle -> PARADA, target unchanged; reset_n pulsed low mid-move -> all outputs 0 asynchronously, pos=0.
REQ-039 Scenario: across all scenarios, a bench assertion SHALL check that motor_up and motor_dn are never both 1 and that pos never exceeds 3.
